// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int SERIAL_ADDER_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_e;

endpackage

// File: rtl/addbit.sv
// Single-bit full adder cell used as the per-bit engine of serial_adder.
module addbit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one addbit cell, operand shift registers, registered carry.
// Optional signed-overflow flag built only when SERIAL_ADDER_OVERFLOW_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);

  sa_state_e        state_q;
  sa_state_e        state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             bit_sum;
  logic             bit_co;
  logic             accept;
  logic             last_bit;

  addbit u_addbit (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .ci  (carry),
    .sum (bit_sum),
    .co  (bit_co)
  );

  assign accept   = in_valid && (state_q == IDLE);
  assign last_bit = (state_q == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // The carry register doubles as cout: after the last bit it holds carry out of the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      sum_sr <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state_q == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= {bit_sum, sum_sr[WIDTH-1:1]};
      carry  <= bit_co;
      cnt    <= cnt + CNT_W'(1);
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic ovf_q;

  // On the last bit, carry holds the carry into the MSB and bit_co the carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (last_bit) begin
      ovf_q <= carry ^ bit_co;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sr;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int W = 8;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_acc [3];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid, checking in_ready stays low and the latency from accept is W cycles.
  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk({tag, "_in_ready_busy"}, in_ready, 0);
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, W);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    a = av; b = bv; cin = ci; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_done(tag);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo & OVF_EN);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drain_out_valid"}, out_valid, 0);
    chk({tag, "_drain_in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;

    do_op("basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    drain("basic");
    do_op("carry1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    drain("carry1");
    do_op("carry2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    drain("carry2");

    // Backpressure: result must hold while new operands are presented and ignored.
    do_op("bp", 8'h9C, 8'h85, 1'b1, 8'h22, 1'b1, 1'b1);
    a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_out_valid", out_valid, 1);
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_sum", sum, 8'h22);
      chk("bp_hold_cout", cout, 1);
    end
    drain("bp");
    do_op("bp_next", 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    drain("bp_next");

    // Reset during the 4th SHIFT cycle.
    a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_ovf", ovf, 0);
    tick();
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1);
    tick();
    chk("midrst_stays_idle", out_valid, 0);
    do_op("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    drain("after_rst");

    do_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    drain("ovf_pos");
    do_op("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    drain("ovf_neg");

    // Back-to-back with both handshakes held high.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int guard;
      logic [W-1:0] es;
      logic         ec;
      case (k)
        0:       begin a = 8'h12; b = 8'h34; cin = 1'b0; es = 8'h46; ec = 1'b0; end
        1:       begin a = 8'hF0; b = 8'h20; cin = 1'b1; es = 8'h11; ec = 1'b1; end
        default: begin a = 8'hAA; b = 8'h55; cin = 1'b1; es = 8'h00; ec = 1'b1; end
      endcase
      guard = 0;
      while (!in_ready && guard < 40) begin
        tick();
        guard++;
      end
      chk("b2b_ready_wait", (guard < 40), 1);
      t_acc[k] = cyc;
      tick();
      a = 8'h00; b = 8'h00; cin = 1'b0;
      guard = 0;
      while (!out_valid && guard < 40) begin
        tick();
        guard++;
      end
      chk("b2b_latency", guard, W);
      chk("b2b_sum", sum, es);
      chk("b2b_cout", cout, ec);
      tick();
      if (k > 0) chk("b2b_spacing", t_acc[k] - t_acc[k-1], 10);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
